// File: rtl/hazard_fwd_scoreboard_pkg.sv
// Shared widths, forward-select encodings and latency clamping for the EX hazard/forwarding block.
package hazard_fwd_scoreboard_pkg;

  localparam int FWD_RF = 0;

  function automatic int reg_w(input int num_regs);
    return $clog2(num_regs);
  endfunction

  function automatic int cnt_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  function automatic int sel_w(input int num_stg);
    return $clog2(num_stg + 2);
  endfunction

  // Long-op result bus sits just past the last pipeline stage code.
  function automatic int fwd_ml(input int num_stg);
    return num_stg + 1;
  endfunction

  // A zero-latency issue still needs one cycle before its result appears on the bus.
  function automatic int clamp_lat(input int lat, input int max_lat);
    if (lat == 0) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/hazard_fwd_scoreboard_if.sv
// EX-side hazard bus: source operands, stage writeback info, long-op issue handshake, select/stall results.
interface hazard_fwd_scoreboard_if #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 8
);
  import hazard_fwd_scoreboard_pkg::*;

  localparam int REG_W = reg_w(NUM_REGS);
  localparam int CNT_W = cnt_w(MAX_LAT);
  localparam int SELW  = sel_w(NUM_STG);

  logic [NUM_SRC*REG_W-1:0] ex_src_idx;
  logic [NUM_SRC-1:0]       ex_src_used;
  logic [NUM_STG-1:0]       stg_regwrite;
  logic [NUM_STG*REG_W-1:0] stg_rd_idx;
  logic [NUM_STG-1:0]       stg_data_vld;
  logic                     ml_issue_valid;
  logic [REG_W-1:0]         ml_issue_rd;
  logic [CNT_W-1:0]         ml_issue_lat;
  logic                     ml_issue_ready;
  logic [NUM_SRC*SELW-1:0]  fwd_sel;
  logic                     stall;

  modport master (
    output ex_src_idx, ex_src_used, stg_regwrite, stg_rd_idx, stg_data_vld,
    output ml_issue_valid, ml_issue_rd, ml_issue_lat,
    input  ml_issue_ready, fwd_sel, stall
  );

  modport slave (
    input  ex_src_idx, ex_src_used, stg_regwrite, stg_rd_idx, stg_data_vld,
    input  ml_issue_valid, ml_issue_rd, ml_issue_lat,
    output ml_issue_ready, fwd_sel, stall
  );

endinterface

// File: rtl/hazard_fwd_scoreboard_ml_scoreboard.sv
// Per-register countdown for in-flight long-latency ops; a count of 1 means the result is on the bus.
module ml_scoreboard
  import hazard_fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 8,
  localparam int REG_W   = reg_w(NUM_REGS),
  localparam int CNT_W   = cnt_w(MAX_LAT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     issue_we,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic [CNT_W-1:0]         issue_lat,
  input  logic [NUM_SRC*REG_W-1:0] src_idx,
  output logic [NUM_SRC*CNT_W-1:0] src_cnt,
  output logic [CNT_W-1:0]         rd_cnt
);

  logic [CNT_W-1:0] cnt [NUM_REGS];

  // A new issue overwrites the decrement of an entry that is just finishing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (flush || r == 0)
          cnt[r] <= '0;
        else if (issue_we && issue_rd == REG_W'(r))
          cnt[r] <= issue_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    src_cnt = '0;
    for (int s = 0; s < NUM_SRC; s++)
      src_cnt[s*CNT_W +: CNT_W] = cnt[src_idx[s*REG_W +: REG_W]];
  end

  assign rd_cnt = cnt[issue_rd];

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// EX forwarding select and stall generation from N writeback stages plus a long-op scoreboard.
module hazard_fwd_scoreboard
  import hazard_fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 8,
  parameter int PERF_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_fwd_scoreboard_if.slave hz,
  input  logic                 flush,
  input  logic                 perf_clr,
  output logic [PERF_W-1:0]    perf_stall_cnt
);

  localparam int REG_W  = reg_w(NUM_REGS);
  localparam int CNT_W  = cnt_w(MAX_LAT);
  localparam int SELW   = sel_w(NUM_STG);
  localparam int FWD_ML = fwd_ml(NUM_STG);

  logic [NUM_SRC*CNT_W-1:0] src_cnt;
  logic [CNT_W-1:0]         rd_cnt;
  logic [CNT_W-1:0]         issue_lat_c;
  logic [NUM_SRC-1:0]       stall_src;
  logic [NUM_SRC*SELW-1:0]  fwd_sel_w;
  logic                     stall_w;
  logic                     issue_ok;
  logic                     issue_we;

  assign issue_lat_c = CNT_W'(clamp_lat(int'(hz.ml_issue_lat), MAX_LAT));

  ml_scoreboard #(
    .NUM_SRC  (NUM_SRC),
    .NUM_REGS (NUM_REGS),
    .MAX_LAT  (MAX_LAT)
  ) u_ml_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .issue_we  (issue_we),
    .issue_rd  (hz.ml_issue_rd),
    .issue_lat (issue_lat_c),
    .src_idx   (hz.ex_src_idx),
    .src_cnt   (src_cnt),
    .rd_cnt    (rd_cnt)
  );

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_W-1:0] idx;
    logic [CNT_W-1:0] c;
    logic [SELW-1:0]  sel;
    logic             st;

    assign idx = hz.ex_src_idx[s*REG_W +: REG_W];
    assign c   = src_cnt[s*CNT_W +: CNT_W];

    // Scan oldest to youngest so the nearest matching stage overrides the scoreboard.
    always_comb begin
      sel = SELW'(FWD_RF);
      st  = 1'b0;
      if (hz.ex_src_used[s] && idx != '0) begin
        if (c > CNT_W'(1))
          st = 1'b1;
        else if (c == CNT_W'(1))
          sel = SELW'(FWD_ML);
        for (int k = NUM_STG - 1; k >= 0; k--) begin
          if (hz.stg_regwrite[k] && hz.stg_rd_idx[k*REG_W +: REG_W] == idx) begin
            sel = SELW'(k + 1);
            st  = !hz.stg_data_vld[k];
          end
        end
      end
    end

    assign fwd_sel_w[s*SELW +: SELW] = sel;
    assign stall_src[s]              = st;
  end

  assign stall_w           = |stall_src;
  assign hz.stall          = stall_w;
  assign hz.fwd_sel        = fwd_sel_w;
  assign issue_ok          = !stall_w && !flush && (rd_cnt <= CNT_W'(1));
  assign hz.ml_issue_ready = issue_ok;
  assign issue_we          = hz.ml_issue_valid && issue_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_stall_cnt <= '0;
    else if (perf_clr)
      perf_stall_cnt <= '0;
    else if (stall_w && perf_stall_cnt != '1)
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench for hazard_fwd_scoreboard: forwarding priority, load-use and long-op stalls, issue, flush, perf.
module tb_hazard_fwd_scoreboard;

  localparam int NUM_SRC  = 2;
  localparam int NUM_STG  = 2;
  localparam int NUM_REGS = 32;
  localparam int MAX_LAT  = 8;
  localparam int PERF_W   = 4;
  localparam int REG_W    = 5;
  localparam int SELW     = 2;
  localparam int ML       = 3;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              perf_clr;
  logic [PERF_W-1:0] perf_stall_cnt;

  int n_tests;
  int n_fail;

  hazard_fwd_scoreboard_if #(
    .NUM_SRC (NUM_SRC), .NUM_STG (NUM_STG), .NUM_REGS (NUM_REGS), .MAX_LAT (MAX_LAT)
  ) hz ();

  hazard_fwd_scoreboard #(
    .NUM_SRC (NUM_SRC), .NUM_STG (NUM_STG), .NUM_REGS (NUM_REGS),
    .MAX_LAT (MAX_LAT), .PERF_W (PERF_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hz             (hz),
    .flush          (flush),
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.ex_src_idx     = '0;
    hz.ex_src_used    = '0;
    hz.stg_regwrite   = '0;
    hz.stg_rd_idx     = '0;
    hz.stg_data_vld   = '1;
    hz.ml_issue_valid = 1'b0;
    hz.ml_issue_rd    = '0;
    hz.ml_issue_lat   = '0;
    flush             = 1'b0;
    perf_clr          = 1'b0;
  endtask

  task automatic set_src(input int s, input int idx, input logic used);
    hz.ex_src_idx[s*REG_W +: REG_W] = REG_W'(idx);
    hz.ex_src_used[s]               = used;
  endtask

  task automatic set_stg(input int k, input int rd, input logic we, input logic vld);
    hz.stg_rd_idx[k*REG_W +: REG_W] = REG_W'(rd);
    hz.stg_regwrite[k]              = we;
    hz.stg_data_vld[k]              = vld;
  endtask

  task automatic issue(input logic v, input int rd, input int lat);
    hz.ml_issue_valid = v;
    hz.ml_issue_rd    = REG_W'(rd);
    hz.ml_issue_lat   = 4'(lat);
  endtask

  function automatic logic [31:0] sel_of(input int s);
    return 32'(hz.fwd_sel[s*SELW +: SELW]);
  endfunction

  // Hold src0 on a register and expect nstall stalled cycles followed by one result-bus cycle.
  task automatic expect_countdown(input string tag, input int rd, input int nstall);
    set_src(0, rd, 1'b1);
    #1;
    for (int i = 0; i < nstall; i++) begin
      check({tag, "_stall"}, 32'(hz.stall), 1);
      tick();
    end
    check({tag, "_sel_ml"}, sel_of(0), ML);
    check({tag, "_nostall"}, 32'(hz.stall), 0);
    tick();
    check({tag, "_sel_rf"}, sel_of(0), 0);
    set_src(0, 0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
    tick();
    check("rst_sel", 32'(hz.fwd_sel), 0);
    check("rst_stall", 32'(hz.stall), 0);
    check("rst_ready", 32'(hz.ml_issue_ready), 1);
    check("rst_perf", 32'(perf_stall_cnt), 0);
    #2 rst_n = 1'b1;
    tick();

    // 1: nearest stage wins, unused source never matches
    set_stg(0, 5, 1'b1, 1'b1);
    set_stg(1, 5, 1'b1, 1'b1);
    set_src(0, 5, 1'b1);
    set_src(1, 5, 1'b0);
    #1;
    check("t1_sel0_near", sel_of(0), 1);
    check("t1_sel1_unused", sel_of(1), 0);
    check("t1_stall", 32'(hz.stall), 0);
    set_stg(0, 6, 1'b1, 1'b1);
    #1;
    check("t1_sel0_stg2", sel_of(0), 2);
    tick();
    idle();

    // 2: load-use stall on the winning stage, blocks issue, clears when data arrives
    set_stg(0, 7, 1'b1, 1'b0);
    set_src(1, 7, 1'b1);
    issue(1'b1, 10, 2);
    #1;
    check("t2_stall", 32'(hz.stall), 1);
    check("t2_ready", 32'(hz.ml_issue_ready), 0);
    check("t2_sel1", sel_of(1), 1);
    tick();
    issue(1'b0, 0, 0);
    set_stg(0, 7, 1'b1, 1'b1);
    #1;
    check("t2_vld_stall", 32'(hz.stall), 0);
    check("t2_vld_sel1", sel_of(1), 1);
    tick();
    idle();
    set_src(1, 10, 1'b1);
    #1;
    check("t2_no_entry", 32'(hz.stall), 0);
    idle();

    // 3: lat=3 -> stall, stall, result bus, register file
    issue(1'b1, 9, 3);
    set_src(0, 9, 1'b1);
    #1;
    check("t3_issue_ready", 32'(hz.ml_issue_ready), 1);
    check("t3_issue_sel", sel_of(0), 0);
    tick();
    issue(1'b0, 0, 0);
    expect_countdown("t3", 9, 2);
    tick();
    idle();

    // 4: WAW block while busy, re-issue at cnt==1 overwrites
    issue(1'b1, 9, 3);
    tick();
    #1;
    check("t4_waw_cnt3", 32'(hz.ml_issue_ready), 0);
    tick();
    check("t4_waw_cnt2", 32'(hz.ml_issue_ready), 0);
    tick();
    issue(1'b1, 9, 4);
    #1;
    check("t4_cnt1_ready", 32'(hz.ml_issue_ready), 1);
    tick();
    issue(1'b0, 0, 0);
    expect_countdown("t4", 9, 3);
    tick();
    idle();

    // 5: flush with concurrent issue cancels everything
    issue(1'b1, 3, 6);
    tick();
    issue(1'b0, 0, 0);
    tick();
    flush = 1'b1;
    issue(1'b1, 4, 2);
    #1;
    check("t5_flush_ready", 32'(hz.ml_issue_ready), 0);
    tick();
    idle();
    set_src(0, 3, 1'b1);
    set_src(1, 4, 1'b1);
    #1;
    check("t5_src3_stall", 32'(hz.stall), 0);
    check("t5_src3_sel", sel_of(0), 0);
    check("t5_src4_sel", sel_of(1), 0);
    tick();
    idle();

    // 6: x0, latency clamping, perf saturation
    set_stg(0, 0, 1'b1, 1'b0);
    set_src(0, 0, 1'b1);
    issue(1'b1, 0, 5);
    #1;
    check("t6_x0_sel", sel_of(0), 0);
    check("t6_x0_stall", 32'(hz.stall), 0);
    check("t6_x0_ready", 32'(hz.ml_issue_ready), 1);
    tick();
    idle();
    issue(1'b1, 11, 0);
    tick();
    issue(1'b0, 0, 0);
    expect_countdown("t6_lat0", 11, 0);
    tick();
    idle();
    issue(1'b1, 12, 15);
    tick();
    issue(1'b0, 0, 0);
    expect_countdown("t6_latmax", 12, 7);
    tick();
    idle();

    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("t6_perf_clr", 32'(perf_stall_cnt), 0);
    set_stg(0, 7, 1'b1, 1'b0);
    set_src(0, 7, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("t6_perf_3", 32'(perf_stall_cnt), 3);
    for (int i = 0; i < 20; i++) tick();
    check("t6_perf_sat", 32'(perf_stall_cnt), 15);
    perf_clr = 1'b1;
    tick();
    check("t6_perf_clr_wins", 32'(perf_stall_cnt), 0);
    perf_clr = 1'b0;
    tick();
    check("t6_perf_restart", 32'(perf_stall_cnt), 1);
    idle();

    // async reset mid-operation
    issue(1'b1, 9, 5);
    tick();
    issue(1'b0, 0, 0);
    set_src(0, 9, 1'b1);
    #1;
    check("rst_mid_pre", 32'(hz.stall), 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_stall", 32'(hz.stall), 0);
    check("rst_mid_perf", 32'(perf_stall_cnt), 0);
    #1 rst_n = 1'b1;
    tick();
    check("rst_mid_after", 32'(hz.stall), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
